// File: rtl/regfile_mp_if.sv
// Port bundle between the issue/writeback side (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*AW-1:0] ra;
  logic [NUM_RD*DW-1:0] rd;
  logic                 wen0;
  logic [AW-1:0]        wa0;
  logic [DW-1:0]        wd0;
  logic                 wen1;
  logic [AW-1:0]        wa1;
  logic [DW-1:0]        wd1;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic [NUM_RD-1:0]    rbusy;
  logic                 init_done;

  modport master (
    output ra, wen0, wa0, wd0, wen1, wa1, wd1, issue_en, issue_addr,
    input  rd, rbusy, init_done
  );

  modport slave (
    input  ra, wen0, wa0, wd0, wen1, wa1, wd1, issue_en, issue_addr,
    output rd, rbusy, init_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports with bypass, sequenced clear after reset.
// Optional pending scoreboard enabled by defining RF_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DW           = 32,
  parameter int DEPTH        = 32,
  parameter int AW           = $clog2(DEPTH),
  parameter int NUM_RD       = 2,
  parameter int SP_INDEX     = 2,
  parameter int SP_RESET_VAL = 256
) (
  input logic         clock,
  input logic         reset,
  regfile_mp_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   mem [DEPTH];
  logic            run_active;
  logic            init_wr;
  logic            wr0_ok, wr1_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == INIT) begin
      cnt_next = cnt_reg + AW'(1);
      if (cnt_reg == AW'(DEPTH - 1))
        state_next = RUN;
    end
  end

  // Reset is also folded in combinationally so nothing leaks out in the reset cycle.
  assign run_active    = (state_reg == RUN) && !reset;
  assign init_wr       = (state_reg == INIT) && !reset;
  assign bus.init_done = run_active;
  assign wr0_ok        = run_active && bus.wen0 && (bus.wa0 != '0);
  assign wr1_ok        = run_active && bus.wen1 && (bus.wa1 != '0);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (init_wr) begin
      mem[cnt_reg] <= (cnt_reg == AW'(SP_INDEX)) ? DW'(SP_RESET_VAL) : '0;
    end else begin
      if (wr0_ok)
        mem[bus.wa0] <= bus.wd0;
      if (wr1_ok)
        mem[bus.wa1] <= bus.wd1;
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_reg, pending_next;

  // Issue is applied after the clears: a newer producer overrides the retiring one.
  always_comb begin
    pending_next = pending_reg;
    if (!run_active) begin
      pending_next = '0;
    end else begin
      if (wr0_ok)
        pending_next[bus.wa0] = 1'b0;
      if (wr1_ok)
        pending_next[bus.wa1] = 1'b0;
      if (bus.issue_en && (bus.issue_addr != '0))
        pending_next[bus.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      pending_reg <= '0;
    else
      pending_reg <= pending_next;
  end
`else
  logic unused_issue;
  assign unused_issue = ^{bus.issue_en, bus.issue_addr};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra_k;
      logic [DW-1:0] rd_k;
      logic          hit0, hit1;

      assign ra_k = bus.ra[gi*AW +: AW];
      assign hit1 = wr1_ok && (bus.wa1 == ra_k);
      assign hit0 = wr0_ok && (bus.wa0 == ra_k);

      always_comb begin
        rd_k = '0;
        if (run_active && (ra_k != '0)) begin
          if (hit1)
            rd_k = bus.wd1;
          else if (hit0)
            rd_k = bus.wd0;
          else
            rd_k = mem[ra_k];
        end
      end

      assign bus.rd[gi*DW +: DW] = rd_k;

`ifdef RF_SCOREBOARD_EN
      assign bus.rbusy[gi] = run_active && (ra_k != '0) && pending_reg[ra_k] && !(hit0 || hit1);
`else
      assign bus.rbusy[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write two-read CPU register file.
- Configurable data width, depth and read-port count.
- Two write ports with write-through bypass.
- Sequenced post-reset clear FSM, so the array maps to RAM without a parallel reset.
- Optional per-register pending scoreboard for the issue stage.
- Sits between decode/issue (read, issue) and writeback (write).

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of registers (power of 2)
AW, $clog2(DEPTH), register address width
NUM_RD, 2, number of read ports (1..4)
SP_INDEX, 2, register loaded with SP_RESET_VAL during init
SP_RESET_VAL, 256, initial value of register SP_INDEX

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; restarts init sequence
ra  input  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
rd  output  NUM_RD*DW  read data, port k at [k*DW +: DW]
wen0  input  1  write port 0 enable
wa0  input  AW  write port 0 address
wd0  input  DW  write port 0 data
wen1  input  1  write port 1 enable
wa1  input  AW  write port 1 address
wd1  input  DW  write port 1 data
issue_en  input  1  mark issue_addr pending (scoreboard)
issue_addr  input  AW  destination register being issued
rbusy  output  NUM_RD  read port k's register is pending
init_done  output  1  high once clear sequence finished

Behaviour:
- Register 0 is hardwired zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - Register 0 is never marked pending.
- FSM states: INIT, RUN.
  - reset=1 forces INIT with counter=0, from any state, including mid-init.
  - INIT: one entry written per cycle, value 0 except entry SP_INDEX = SP_RESET_VAL.
  - INIT: counter increments each cycle; after entry DEPTH-1 is written, next state is RUN.
  - init_done is 0 during reset and INIT; it rises on the first RUN cycle, DEPTH cycles after reset deasserts.
  - In INIT, wen0/wen1/issue_en are ignored, all rd outputs read 0 and all rbusy read 0.
- RUN, write:
  - data[waN] <= wdN at the rising edge when wenN=1 and waN!=0.
  - If wa0==wa1 with both enabled, port 1 wins.
- RUN, read is combinational, zero latency, with bypass priority:
  - port 1 write match (wen1, wa1==ra_k, wa1!=0) -> wd1;
  - else port 0 match -> wd0;
  - else array contents.
- Reset values:
  - rd = 0.
  - rbusy = 0.
  - init_done = 0.
  - all pending bits = 0.

Optional Feature:
Macro RF_SCOREBOARD_EN.
- Defined:
  - DEPTH-bit pending vector, updated in RUN only.
  - issue_en && issue_addr!=0 sets pending[issue_addr].
  - A write (wenN && waN!=0) clears pending[waN].
  - Same-cycle set and clear of the same register: set wins, since it is a newer producer.
  - rbusy[k] = pending[ra_k] && !(bypass hit on port k this cycle) && ra_k!=0.
  - Pending vector is cleared on reset and throughout INIT.
- Undefined:
  - No pending storage.
  - rbusy tied to 0.
  - issue_en and issue_addr unused.

Test Plan:
1. Reset for 3 cycles then release, DEPTH=32 -> init_done low for exactly 32 cycles then high; reg 2 reads 256, regs 0,1,3..31 read 0.
2. In RUN: wen0=1, wa0=5, wd0=0xDEADBEEF with ra port0=5 in the same cycle -> rd port0 = 0xDEADBEEF combinationally; next cycle, with no write, still 0xDEADBEEF.
3. wen0 and wen1 both to reg 7, wd0=0x11, wd1=0x22 -> bypass shows 0x22 that cycle; 0x22 stored afterwards. Write to reg 0 -> reg 0 still reads 0.
4. Assert reset during INIT at counter=10 -> counter restarts; init_done rises 32 cycles after the new reset release; writes issued during INIT are not stored.
5. RF_SCOREBOARD_EN: issue reg 9 -> rbusy=1 on a port reading 9. In the writeback cycle for reg 9, rbusy=0 (bypass) and pending cleared. Issue reg 9 and write reg 9 in the same cycle -> remains pending.
6. RF_SCOREBOARD_EN undefined -> rbusy constantly 0 regardless of issue_en=1, issue_addr=4.
